// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI bus: drives one-hot active-low selects,
// enforces select setup/hold/gap timing and runs the mode-0 byte shift engine.
module spi_bus_arbiter #(
    parameter int NUM_REQ  = 5,
    parameter int CLK_DIV  = 2,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2,
    parameter int SS_GAP   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_i,
    output logic [NUM_REQ-1:0]     grant_o,
    input  logic [8*NUM_REQ-1:0]   tx_data_i,
    input  logic [NUM_REQ-1:0]     wr_i,
    output logic                   ready_o,
    output logic [7:0]             rx_data_o,
    output logic                   rx_valid_o,
    output logic [NUM_REQ-1:0]     ss_n_o,
    output logic                   sck_o,
    output logic                   mosi_o,
    input  logic                   miso_i,
    output logic [2:0]             dbg_state_o
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (SS_SETUP > SS_HOLD)
                           ? ((SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP)
                           : ((SS_HOLD > SS_GAP) ? SS_HOLD : SS_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_OWN   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_winner;
    logic [IDX_W-1:0]   r_rr;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [3:0]         r_edge;
    logic               r_sck;
    logic               r_mosi;
    logic [7:0]         r_tx;
    logic [7:0]         r_rx;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;

    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_scan;
    logic [NUM_REQ-1:0] w_onehot;
    logic [7:0]         w_own_byte;
    logic               w_own_req;
    logic               w_accept;
    logic               w_tick;
    logic               w_last;

    // Handshake: wr_i[owner] is a one-cycle start strobe honoured only while
    // ready_o is high; ready_o falls the next cycle and rises again together
    // with rx_valid_o when the byte completes, so a strobe in that same cycle
    // starts the next byte with no dead SCK period.
    assign w_onehot   = NUM_REQ'(1) << r_winner;
    assign w_own_byte = tx_data_i[{r_winner, 3'b000} +: 8];
    assign w_own_req  = req_i[r_winner];
    assign w_accept   = (r_state == S_OWN) && wr_i[r_winner];
    assign w_tick     = (r_state == S_SHIFT) && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last     = w_tick && (r_edge == 4'd15);

    // Scan downward so the nearest index after the last owner is written last.
    always_comb begin
        w_pick = r_rr;
        w_scan = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_scan = IDX_W'((int'(r_rr) + i) % NUM_REQ);
            if (req_i[w_scan]) begin
                w_pick = w_scan;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (|req_i) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (!w_own_req) w_state_nxt = S_HOLD;
                else if (r_cnt == CNT_W'(SS_SETUP - 1)) w_state_nxt = S_OWN;
            end
            S_OWN: begin
                if (wr_i[r_winner]) w_state_nxt = S_SHIFT;
                else if (!w_own_req) w_state_nxt = S_HOLD;
            end
            S_SHIFT: begin
                if (w_last) w_state_nxt = w_own_req ? S_OWN : S_HOLD;
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(SS_HOLD - 1)) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(SS_GAP - 1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= '0;
            r_winner <= '0;
            r_rr     <= '0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_SETUP || r_state == S_HOLD || r_state == S_GAP) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (r_state == S_IDLE && (|req_i)) begin
                r_winner <= w_pick;
            end
            if (r_state == S_HOLD && w_state_nxt == S_GAP) begin
                r_rr <= r_winner;
            end
        end
    end

    // Even edge counts are rising SCK edges (sample MISO), odd are falling (advance MOSI).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div      <= '0;
            r_edge     <= '0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_tx   <= w_own_byte;
                r_mosi <= w_own_byte[7];
                r_div  <= '0;
                r_edge <= '0;
                r_sck  <= 1'b0;
            end else if (r_state == S_SHIFT) begin
                if (w_tick) begin
                    r_div  <= '0;
                    r_edge <= r_edge + 4'd1;
                    r_sck  <= ~r_sck;
                    if (!r_edge[0]) begin
                        r_rx <= {r_rx[6:0], miso_i};
                    end else begin
                        r_tx   <= {r_tx[6:0], 1'b0};
                        r_mosi <= r_tx[6];
                    end
                    if (w_last) begin
                        r_rx_data  <= r_rx;
                        r_rx_valid <= 1'b1;
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign ready_o     = (r_state == S_OWN);
    assign grant_o     = (r_state == S_OWN || r_state == S_SHIFT) ? w_onehot : '0;
    assign ss_n_o      = (r_state == S_SETUP || r_state == S_OWN ||
                          r_state == S_SHIFT || r_state == S_HOLD) ? ~w_onehot : '1;
    assign sck_o       = r_sck;
    assign mosi_o      = r_mosi;
    assign rx_data_o   = r_rx_data;
    assign rx_valid_o  = r_rx_valid;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed-sequence bench for spi_bus_arbiter with random data bytes, a
// behavioural SPI slave, a round-robin reference picker and an rx scoreboard.
module tb_spi_bus_arbiter;

    localparam int N     = 5;
    localparam int CD    = 2;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int GAP   = 1;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   req_i;
    logic [N-1:0]   grant_o;
    logic [8*N-1:0] tx_data_i;
    logic [N-1:0]   wr_i;
    logic           ready_o;
    logic [7:0]     rx_data_o;
    logic           rx_valid_o;
    logic [N-1:0]   ss_n_o;
    logic           sck_o;
    logic           mosi_o;
    logic           miso_i;
    logic [2:0]     dbg_state_o;

    spi_bus_arbiter #(
        .NUM_REQ(N), .CLK_DIV(CD), .SS_SETUP(SETUP), .SS_HOLD(HOLD), .SS_GAP(GAP)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .grant_o(grant_o),
        .tx_data_i(tx_data_i), .wr_i(wr_i), .ready_o(ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .ss_n_o(ss_n_o),
        .sck_o(sck_o), .mosi_o(mosi_o), .miso_i(miso_i), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bus monitors and slave model ----------------
    int         rise_cnt = 0;
    int         fall_cnt = 0;
    logic [7:0] mosi_cap = 8'h00;
    always @(posedge sck_o) begin
        rise_cnt <= rise_cnt + 1;
        mosi_cap <= {mosi_cap[6:0], mosi_o};
    end
    always @(negedge sck_o) fall_cnt <= fall_cnt + 1;

    // miso_mode 0: loop back MOSI, 1: held high, 2: slave shifts out slv_byte
    int         miso_mode = 0;
    logic [7:0] slv_byte  = 8'h00;
    int         slv_base  = 0;
    function automatic logic slv_bit(input logic [7:0] b, input int k);
        if (k >= 0 && k < 8) return b[7-k];
        return 1'b0;
    endfunction
    assign miso_i = (miso_mode == 0) ? mosi_o :
                    (miso_mode == 1) ? 1'b1 : slv_bit(slv_byte, fall_cnt - slv_base);

    logic [7:0] rx_dat[256];
    int         rx_cyc[256];
    int         rx_n = 0;
    int         ovl_err = 0;
    int         sck_idle_err = 0;
    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            rx_dat[rx_n] <= rx_data_o;
            rx_cyc[rx_n] <= cyc;
            rx_n         <= rx_n + 1;
        end
        if ($countones(~ss_n_o) > 1) ovl_err <= ovl_err + 1;
        if (sck_o && (&ss_n_o)) sck_idle_err <= sck_idle_err + 1;
    end

    // ---------------- scoreboard / reference model ----------------
    logic [7:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int last_owner = 0;
    int rel_cyc = 0;
    int ss_cyc = 0;

    function automatic int rr_pick(input int last, input logic [N-1:0] mask);
        for (int i = 1; i <= N; i++) begin
            if (mask[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic select_and_grant(input int w, input int exp_ss_cyc, input string tag);
        logic [N-1:0] oh;
        logic [N-1:0] exp_ss;
        int k;
        oh = N'(1) << w;
        exp_ss = ~oh;
        k = 0;
        while ((&ss_n_o) && k < 50) begin
            tick();
            k++;
        end
        ss_cyc = cyc;
        chk({tag, " ss_n"}, ss_n_o, exp_ss);
        chk({tag, " ss cycle"}, cyc, exp_ss_cyc);
        chk({tag, " grant before setup"}, grant_o, 0);
        repeat (SETUP) tick();
        chk({tag, " grant"}, grant_o, oh);
        chk({tag, " ready"}, ready_o, 1);
        last_owner = w;
    endtask

    task automatic send_byte(input int w, input logic [7:0] tx, input int mode,
                             input logic [7:0] slv, output int t);
        tx_data_i[8*w +: 8] = tx;
        wr_i[w]   = 1'b1;
        miso_mode = mode;
        slv_byte  = slv;
        slv_base  = fall_cnt;
        if (mode == 0) exp_q.push_back(tx);
        else if (mode == 1) exp_q.push_back(8'hFF);
        else exp_q.push_back(slv);
        t = cyc;
        tick();
        wr_i = '0;
    endtask

    task automatic finish_byte(input int t, input int idx, input string tag);
        int k;
        logic [7:0] e;
        k = 0;
        while (rx_n <= idx && k < 40 * CD * 8) begin
            tick();
            k++;
        end
        chk({tag, " rx_valid seen"}, rx_n > idx, 1);
        e = exp_q.pop_front();
        chk({tag, " rx cycle"}, rx_cyc[idx], t + 1 + 16 * CD);
        chk({tag, " rx_data"}, rx_dat[idx], e);
    endtask

    task automatic release_bus(input int w, input string tag);
        logic [N-1:0] oh;
        logic [N-1:0] exp_ss;
        logic [N-1:0] all1;
        oh = N'(1) << w;
        exp_ss = ~oh;
        all1 = '1;
        req_i[w] = 1'b0;
        rel_cyc = cyc;
        tick();
        chk({tag, " grant drop"}, grant_o, 0);
        chk({tag, " ready drop"}, ready_o, 0);
        repeat (HOLD - 1) tick();
        chk({tag, " ss held"}, ss_n_o, exp_ss);
        tick();
        chk({tag, " ss released"}, ss_n_o, all1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t, t1, t2, r0, s0, w, k, nrl;
        logic [7:0] tx, slv;
        logic [N-1:0] all1;
        logic [N-1:0] ss0;
        all1 = '1;
        ss0 = ~(N'(1));

        rst_ni = 1'b0; req_i = '0; wr_i = '0; tx_data_i = '0;
        repeat (3) tick();
        chk("rst grant", grant_o, 0);
        chk("rst ss_n", ss_n_o, all1);
        chk("rst sck", sck_o, 0);
        chk("rst mosi", mosi_o, 0);
        chk("rst ready", ready_o, 0);
        chk("rst rx_data", rx_data_o, 0);
        chk("rst rx_valid", rx_valid_o, 0);
        rst_ni = 1'b1;
        tick();

        // requester 0 alone, 0xA5 looped back
        req_i[0] = 1'b1;
        w = rr_pick(last_owner, req_i);
        select_and_grant(w, cyc + 1, "arb0");
        r0 = rx_n; s0 = rise_cnt;
        send_byte(0, 8'hA5, 0, 8'h00, t);
        chk("a5 ready low", ready_o, 0);
        chk("a5 first bit", mosi_o, 1);
        chk("a5 sck idle", sck_o, 0);
        finish_byte(t, r0, "a5");
        chk("a5 ready back", ready_o, 1);
        chk("a5 sck pulses", rise_cnt - s0, 8);
        chk("a5 mosi bits", mosi_cap, 8'hA5);
        release_bus(0, "rel0");

        // requester 1 with a random slave byte, so that 1 is the last owner
        req_i[1] = 1'b1;
        w = rr_pick(last_owner, req_i);
        select_and_grant(w, rel_cyc + 2 + HOLD + GAP, "arb1");
        tx = 8'($urandom); slv = 8'($urandom);
        r0 = rx_n;
        send_byte(1, tx, 2, slv, t);
        finish_byte(t, r0, "rnd1");
        chk("rnd1 mosi bits", mosi_cap, tx);
        release_bus(1, "rel1");

        // 1 and 3 together after owner 1: 3 first, then 1
        req_i[1] = 1'b1; req_i[3] = 1'b1;
        w = rr_pick(last_owner, req_i);
        select_and_grant(w, rel_cyc + 2 + HOLD + GAP, "rr first");
        tx = 8'($urandom);
        r0 = rx_n;
        send_byte(w, tx, 0, 8'h00, t);
        finish_byte(t, r0, "rr first byte");
        release_bus(w, "rr first rel");
        w = rr_pick(last_owner, req_i);
        select_and_grant(w, rel_cyc + 2 + HOLD + GAP, "rr second");
        chk("rr gap length", (ss_cyc - (rel_cyc + 1)) >= (HOLD + GAP), 1);
        tx = 8'($urandom); slv = 8'($urandom);
        r0 = rx_n;
        send_byte(w, tx, 2, slv, t);
        finish_byte(t, r0, "rr second byte");
        release_bus(w, "rr second rel");

        // owner 2: 0x00 then 0xFF back to back, MISO held high
        req_i[2] = 1'b1;
        w = rr_pick(last_owner, req_i);
        select_and_grant(w, rel_cyc + 2 + HOLD + GAP, "b2b arb");
        r0 = rx_n; s0 = rise_cnt;
        send_byte(2, 8'h00, 1, 8'h00, t1);
        k = 0;
        while (!ready_o && k < 200) begin
            tick();
            k++;
        end
        chk("b2b ready rise cycle", cyc, t1 + 1 + 16 * CD);
        chk("b2b rx_valid with ready", rx_valid_o, 1);
        send_byte(2, 8'hFF, 1, 8'h00, t2);
        chk("b2b second start bit", mosi_o, 1);
        finish_byte(t1, r0, "b2b byte0");
        finish_byte(t2, r0 + 1, "b2b byte1");
        chk("b2b sck pulses", rise_cnt - s0, 16);
        chk("b2b mosi bits", mosi_cap, 8'hFF);
        release_bus(2, "b2b rel");

        // non-owner strobes while 0 owns and is idle
        req_i[0] = 1'b1;
        w = rr_pick(last_owner, req_i);
        select_and_grant(w, rel_cyc + 2 + HOLD + GAP, "nonown arb");
        s0 = rise_cnt;
        tx_data_i = {$urandom, $urandom};
        wr_i[1] = 1'b1; wr_i[3] = 1'b1;
        tick();
        wr_i = '0;
        nrl = 0;
        repeat (10) begin
            tick();
            if (!ready_o) nrl++;
        end
        chk("nonown ready low cycles", nrl, 0);
        chk("nonown sck pulses", rise_cnt - s0, 0);

        // request dropped in the same cycle as the byte strobe
        tx = 8'($urandom); slv = 8'($urandom);
        r0 = rx_n;
        req_i[0] = 1'b0;
        send_byte(0, tx, 2, slv, t);
        finish_byte(t, r0, "drop+wr");
        chk("drop+wr mosi bits", mosi_cap, tx);
        chk("drop+wr ready", ready_o, 0);
        chk("drop+wr grant", grant_o, 0);
        chk("drop+wr ss at end", ss_n_o, ss0);
        repeat (HOLD - 1) tick();
        chk("drop+wr ss held", ss_n_o, ss0);
        tick();
        chk("drop+wr ss released", ss_n_o, all1);
        rel_cyc = t + 16 * CD;

        // reset at the 4th SCK rising edge of a byte from requester 4
        req_i[4] = 1'b1;
        w = rr_pick(last_owner, req_i);
        select_and_grant(w, rel_cyc + 2 + HOLD + GAP, "rst arb");
        r0 = rx_n; s0 = rise_cnt;
        send_byte(4, 8'($urandom), 0, 8'h00, t);
        k = 0;
        while ((rise_cnt - s0) < 4 && k < 100) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        chk("rst mid rise count", rise_cnt - s0, 4);
        rst_ni = 1'b0;
        #1;
        chk("rst mid ss_n", ss_n_o, all1);
        chk("rst mid sck", sck_o, 0);
        chk("rst mid grant", grant_o, 0);
        chk("rst mid ready", ready_o, 0);
        void'(exp_q.pop_back());
        req_i = '0;
        repeat (3) tick();
        chk("rst mid no rx_valid", rx_n, r0);
        chk("rst mid rx_data", rx_data_o, 0);
        rst_ni = 1'b1;
        last_owner = 0;
        tick();
        req_i[3] = 1'b1; req_i[4] = 1'b1;
        w = rr_pick(last_owner, req_i);
        select_and_grant(w, cyc + 1, "post rst arb");
        tx = 8'($urandom);
        r0 = rx_n;
        send_byte(w, tx, 0, 8'h00, t);
        finish_byte(t, r0, "post rst byte");
        chk("post rst mosi bits", mosi_cap, tx);
        release_bus(w, "post rst rel");
        req_i = '0;
        repeat (8) tick();

        chk("ss overlap cycles", ovl_err, 0);
        chk("sck while deselected", sck_idle_err, 0);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the board's single SPI bus (SCK/MOSI/MISO) between up to NUM_REQ on-chip masters: OLED, uSD, VS codec, DES and APP flash. The block grants the bus round-robin and drives the one-hot active-low slave selects. It contains the mode-0 byte shift engine and enforces chip-select setup, hold and turnaround gaps. It sits between the core's peripheral blocks and the top-level SS/SCK/MOSI/MISO pins.

## Interface
- NUM_REQ, 5, number of requesters / slave selects (2..8)
- CLK_DIV, 2, system clocks per SCK half-period (>=1); SCK = clk/(2*CLK_DIV)
- SS_SETUP, 2, clocks from SS assertion to grant/first byte accepted (>=1)
- SS_HOLD, 2, clocks from last byte end to SS deassertion (>=1)
- SS_GAP, 1, clocks with all SS high before next grant (>=1)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  NUM_REQ  bus request per requester; held high for whole transaction
- grant_o  out  NUM_REQ  one-hot ownership, valid once SS setup is done
- tx_data_i  in  8*NUM_REQ  byte per requester, requester n on [8n+7:8n]
- wr_i  in  NUM_REQ  one-cycle byte-start strobe per requester
- ready_o  out  1  engine idle and owner may strobe wr_i
- rx_data_o  out  8  last received byte; holds until next byte completes
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates
- ss_n_o  out  NUM_REQ  active-low selects, at most one low
- sck_o  out  1  SPI clock, idle low (mode 0)
- mosi_o  out  1  serial out, MSB first
- miso_i  in  1  serial in

## Operation
- Reset values: grant_o=0, ss_n_o=all ones, sck_o=0, mosi_o=0, ready_o=0, rx_data_o=0x00, rx_valid_o=0, state IDLE, rr pointer=0.
- Reset mid-transfer: all outputs return to their reset values immediately, asynchronously. No partial rx_valid_o is produced.
- FSM states: IDLE, SETUP, OWN, SHIFT, HOLD, GAP.
- IDLE: if any req_i is high, select a winner by round-robin. Search starts at index rr+1 mod NUM_REQ, wrapping. Drive ss_n_o[winner]=0, go to SETUP.
- SETUP: count SS_SETUP clocks.
  - At the end, go to OWN: grant_o[winner]=1, ready_o=1.
  - If req_i[winner] drops during SETUP, go to HOLD.
- OWN:
  - wr_i[winner] high: latch its tx byte, ready_o=0, go to SHIFT.
  - req_i[winner] low: go to HOLD.
  - If both happen in the same cycle, wr wins; the byte is sent, then HOLD follows.
- wr_i from non-owners is always ignored. wr_i while ready_o=0 is ignored.
- SHIFT: mode 0, 8 bits.
  - MOSI changes on SCK falling edges; the first bit is driven before the first rising edge.
  - MISO is sampled on rising edges and shifted MSB first.
  - After the 8th falling edge: update rx_data_o, pulse rx_valid_o, return to OWN.
  - If req_i has dropped, go to HOLD instead.
- HOLD: grant_o=0, ready_o=0, SS stays low for SS_HOLD clocks. Then ss_n_o=all ones, rr=winner, go to GAP.
- GAP: all SS high for SS_GAP clocks, then IDLE. Pending requests are arbitrated there.
- A requester dropping and re-raising req_i within HOLD/GAP does not keep ownership. Other pending requesters win first.

## Timing
- Arbitration: req_i high in IDLE at cycle T gives ss_n_o low at T+1 and grant_o/ready_o high at T+1+SS_SETUP.
- Byte: wr_i accepted at T.
  - T+1: ready_o=0, mosi_o=bit7, sck_o=0.
  - Rising edge k (k=1..8) at T+1+(2k-1)*CLK_DIV.
  - Falling edge k at T+1+2k*CLK_DIV.
  - rx_valid_o=1 and ready_o=1 at T+1+16*CLK_DIV.
- Back-to-back: wr_i in the same cycle ready_o rises gives the next byte's bit7 at the following cycle. No extra idle SCK.
- Release: req drop seen in OWN at T gives grant_o=0 at T+1 and ss_n_o high at T+1+SS_HOLD. The next grant's SS goes low no earlier than T+2+SS_HOLD+SS_GAP.
- ss_n_o never has two bits low in the same cycle. sck_o toggles only in SHIFT.

## Test plan
- Reset, then single requester 0 sends 0xA5 with MISO looping back MOSI. Required:
  - ss_n_o[0] low 1 cycle after req_i.
  - grant after 2 more cycles.
  - 8 SCK pulses, MOSI pattern 1,0,1,0,0,1,0,1.
  - rx_data_o=0xA5, rx_valid_o pulses at T+33 with CLK_DIV=2.
- Requesters 1 and 3 request simultaneously after owner 1 last. Required: 3 wins first, then 1. The ss_n_o gap between them is ≥ SS_HOLD+SS_GAP cycles with all ones.
- Owner 2 writes 0x00 then 0xFF back-to-back on ready_o, with MISO held 1. Required: 16 contiguous SCK pulses, and two rx_valid_o pulses with rx_data_o=0xFF both times.
- Non-owner strobes wr_i while requester 0 owns the bus and is idle. Required: no SCK activity and ready_o stays 1.
- req_i drops in the same cycle as wr_i. Required: the byte completes with rx_valid_o, then HOLD and ss_n_o high SS_HOLD cycles later.
- rst_ni low mid-byte, at the 4th SCK rising edge. Required: ss_n_o all ones and sck_o=0 in the same cycle, no rx_valid_o, and a clean arbitration after release.
